iter_divider: RTL and testbench

//   Multi-cycle radix-2 restoring divider; responder side of the EX-stage divide handshake.
//   EX holds start_i plus operands while it stalls the pipeline.
//   The divider answers with a one-cycle ready_o pulse carrying {remainder, quotient}.

---
 rtl/iter_divider_pkg.sv | 29 ++
 rtl/iter_divider_div_step.sv | 41 ++++
 rtl/iter_divider.sv | 176 +++++++++++++++++
 tb/tb_iter_divider.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/iter_divider_pkg.sv
// ============================================================================
// Module      : iter_divider_pkg
// Description : Shared state codes and handshake constants for the iterative
//               radix-2 restoring divider.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package iter_divider_pkg;

    // Divider control states (2-bit encoding shared with the EX stage)
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    // Request levels driven by EX on start_i
    localparam logic c_DIV_START = 1'b1;
    localparam logic c_DIV_STOP  = 1'b0;

    // Levels of the ready_o response
    localparam logic c_DIV_RESULT_READY     = 1'b1;
    localparam logic c_DIV_RESULT_NOT_READY = 1'b0;

endpackage : iter_divider_pkg

`default_nettype wire

// File: rtl/iter_divider_div_step.sv
// ============================================================================
// Module      : iter_divider_div_step
// Description : One combinational restoring-division step: shift the
//               {remainder, quotient} pair left by one and try to subtract
//               the divisor from the widened partial remainder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module iter_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quot,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quot
);

    // Partial remainder after the shift needs one extra bit; the trial
    // subtraction carries one more so its MSB acts as the borrow flag.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_ge;
    logic             w_unused_bits;

    assign w_shift = {i_rem, i_quot[WIDTH-1]};
    assign w_trial = {1'b0, w_shift} - {2'b00, i_divisor};
    assign w_ge    = ~w_trial[WIDTH+1];

    // When the trial succeeds the difference is below the divisor and fits
    // in WIDTH bits; when it fails the shifted value is below the divisor
    // too, so bit WIDTH of either is always zero.
    assign o_rem  = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quot = {i_quot[WIDTH-2:0], w_ge};

    assign w_unused_bits = &{1'b0, w_trial[WIDTH], w_shift[WIDTH]};

endmodule : iter_divider_div_step

`default_nettype wire

// File: rtl/iter_divider.sv
// ============================================================================
// Module      : iter_divider
// Description : Multi-cycle radix-2 restoring divider answering the EX-stage
//               divide handshake. EX holds start_i and the operands; the
//               divider returns {remainder, quotient} with a one-cycle
//               ready_o pulse. Handles signed (DIV) and unsigned (DIVU).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int              c_CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    div_state_t           r_state;
    div_state_t           w_state_nxt;

    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_divisor;
    logic                 r_sign1;
    logic                 r_sign2;
    logic                 r_signed;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_ready;

    logic                 w_load;
    logic                 w_step;
    logic                 w_ready_nxt;
    logic [2*WIDTH-1:0]   w_result_nxt;

    logic [WIDTH-1:0]     w_op1_abs;
    logic [WIDTH-1:0]     w_op2_abs;
    logic [WIDTH-1:0]     w_step_rem;
    logic [WIDTH-1:0]     w_step_quot;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    // Magnitudes of the operands; negation only applies to signed negatives.
    // The most negative value maps onto itself, which as an unsigned
    // magnitude is exactly right.
    assign w_op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    iter_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quot    (r_quot),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quot    (w_step_quot)
    );

    // Sign fix-up applied to the final step's output as it is registered:
    // quotient negative when operand signs differ, remainder follows dividend.
    assign w_quot_fix = (r_signed && (r_sign1 ^ r_sign2)) ? (~w_step_quot + 1'b1) : w_step_quot;
    assign w_rem_fix  = (r_signed && r_sign1)             ? (~w_step_rem + 1'b1)  : w_step_rem;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath control; the response registers are
    // loaded on the transition into END so they are valid during END.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_ready_nxt  = c_DIV_RESULT_NOT_READY;
        w_result_nxt = '0;

        case (r_state)
            DIV_FREE: begin
                if (start_i == c_DIV_START) begin
                    if (!annul_i && (opdata2_i == '0)) begin
                        w_state_nxt = DIV_BY_ZERO;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = DIV_ON;
                    end
                end
            end

            DIV_BY_ZERO: begin
                w_state_nxt  = DIV_END;
                w_ready_nxt  = c_DIV_RESULT_READY;
                w_result_nxt = '0;
            end

            DIV_ON: begin
                if (annul_i || (start_i == c_DIV_STOP)) begin
                    w_state_nxt = DIV_FREE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt  = DIV_END;
                        w_ready_nxt  = c_DIV_RESULT_READY;
                        w_result_nxt = {w_rem_fix, w_quot_fix};
                    end
                end
            end

            DIV_END: begin
                w_state_nxt = DIV_FREE;
            end

            default: begin
                w_state_nxt = DIV_FREE;
            end
        endcase
    end

    // Operand latch and one shift/subtract step per ON cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_signed  <= 1'b0;
        end else if (w_load) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= w_op1_abs;
            r_divisor <= w_op2_abs;
            r_sign1   <= opdata1_i[WIDTH-1];
            r_sign2   <= opdata2_i[WIDTH-1];
            r_signed  <= signed_div_i;
        end else if (w_step) begin
            r_cnt     <= r_cnt + 1'b1;
            r_rem     <= w_step_rem;
            r_quot    <= w_step_quot;
        end
    end

    // Registered response; zero outside the single ready cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready  <= c_DIV_RESULT_NOT_READY;
            r_result <= '0;
        end else begin
            r_ready  <= w_ready_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign ready_o  = r_ready;
    assign result_o = r_result;

endmodule : iter_divider

`default_nettype wire

// File: tb/tb_iter_divider.sv
// ============================================================================
// Module      : tb_iter_divider
// Description : Directed, table-driven bench for iter_divider plus
//               hand-written multi-cycle sequences (annul, reset in ON,
//               operand changes during ON, back-to-back requests).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iter_divider;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    iter_divider #(
        .WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance edges until ready_o is seen; cyc is the cycle of ready counting
    // the current cycle as 1, or 0 if the budget ran out.
    task automatic wait_ready(input int max, output int cyc);
        bit found;
        found = 1'b0;
        cyc   = 0;
        for (int k = 1; k <= max && !found; k++) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) begin
                cyc   = k + 1;
                found = 1'b1;
            end
        end
    endtask

    // Advance n edges, counting cycles where ready_o is high
    task automatic tick_n(input int n, output int seen);
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0) seen++;
        end
    endtask

    task automatic drive_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
    endtask

    task automatic drop_and_check_idle(input string name);
        start_i   = 1'b0;
        opdata1_i = 32'h0;
        opdata2_i = 32'h0;
        @(posedge clk);
        #1;
        check64({name, " after"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    task automatic apply_vec(input vec_t v);
        int cyc;
        drive_op(v.sgn, v.a, v.b);
        wait_ready(60, cyc);
        check_int({v.name, " latency"}, cyc, v.lat);
        check64({v.name, " result"}, result_o, {v.r, v.q});
        drop_and_check_idle(v.name);
    endtask

    initial begin
        int cyc;
        int seen;

        vecs[0]  = '{"u100/7",      1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        34};
        vecs[1]  = '{"s-7/2",       1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 34};
        vecs[2]  = '{"s7/-2",       1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        34};
        vecs[3]  = '{"s_ovf",       1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        34};
        vecs[4]  = '{"u5/0",        1'b0, 32'd5,        32'd0,        32'd0,        32'd0,        3};
        vecs[5]  = '{"s5/0",        1'b1, 32'd5,        32'd0,        32'd0,        32'd0,        3};
        vecs[6]  = '{"uFFFF/1",     1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        34};
        vecs[7]  = '{"s-100/-7",    1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 34};
        vecs[8]  = '{"uFFFF/16",    1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        34};
        vecs[9]  = '{"u3/5",        1'b0, 32'd3,        32'd5,        32'd0,        32'd3,        34};
        vecs[10] = '{"u8000/FFFF",  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 34};

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset result", result_o, 64'd0);
        check_int("reset ready", int'(ready_o), 0);
        rst = 1'b0;
        tick_n(2, seen);
        check_int("idle no ready", seen, 0);

        for (int i = 0; i < 11; i++) begin
            apply_vec(vecs[i]);
        end

        // Annul in ON cycle 10, then a fresh op in the following IDLE cycle
        drive_op(1'b0, 32'd100, 32'd7);
        tick_n(9, seen);
        annul_i = 1'b1;
        tick_n(1, cyc);
        check_int("annul no ready", seen + cyc, 0);
        drive_op(1'b0, 32'hFFFFFFFF, 32'd1);
        wait_ready(60, cyc);
        check_int("post-annul latency", cyc, 34);
        check64("post-annul result", result_o, {32'd0, 32'hFFFFFFFF});
        drop_and_check_idle("post-annul");

        // Operand inputs change during ON; the latched values must win
        drive_op(1'b0, 32'd100, 32'd7);
        tick_n(5, seen);
        opdata1_i    = 32'hFFFF1234;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b1;
        wait_ready(60, cyc);
        check_int("opchg latency", (cyc == 0) ? 0 : cyc + 5, 34);
        check64("opchg result", result_o, {32'd2, 32'd14});
        drop_and_check_idle("opchg");

        // Back-to-back: start held through END starts a second op in IDLE
        drive_op(1'b0, 32'd100, 32'd7);
        wait_ready(60, cyc);
        check_int("b2b first latency", cyc, 34);
        check64("b2b first result", result_o, {32'd2, 32'd14});
        opdata1_i = 32'd1000;
        opdata2_i = 32'd10;
        @(posedge clk);
        #1;
        check64("b2b idle gap", {63'd0, ready_o} | result_o, 64'd0);
        wait_ready(60, cyc);
        check_int("b2b second latency", cyc, 34);
        check64("b2b second result", result_o, {32'd0, 32'd100});
        drop_and_check_idle("b2b");

        // Synchronous reset in ON cycle 20; start stays high so a fresh op
        // begins in the first cycle after reset is released
        drive_op(1'b0, 32'd100, 32'd7);
        tick_n(19, seen);
        rst = 1'b1;
        tick_n(1, cyc);
        check_int("rst no ready", seen + cyc, 0);
        check64("rst result", result_o, 64'd0);
        rst       = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        wait_ready(60, cyc);
        check_int("post-rst latency", cyc, 34);
        check64("post-rst result", result_o, {32'd6, 32'd142});
        drop_and_check_idle("post-rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_iter_divider

`default_nettype wire
